// File: rtl/mul_ctrl_pkg.sv
// Shared types and widths for the sequential shift-add multiplier.
// Operand, product and RUN-counter widths plus the controller states.
package mul_ctrl_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/cla_sixteen.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
// Group generate/propagate terms feed a second-level carry chain.
module cla_sixteen (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [15:0] c;

  function automatic logic [4:0] chain(
    input logic [3:0] gi,
    input logic [3:0] pi,
    input logic       ci
  );
    logic [4:0] r;
    r[0] = ci;
    for (int j = 0; j < 4; j++) begin
      r[j+1] = gi[j] | (pi[j] & r[j]);
    end
    return r;
  endfunction

  assign g = a & b;
  assign p = a ^ b;

  // group generate/propagate, then lookahead across groups
  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc = chain(gg, gp, cin);
  end

  // per-bit carries inside each group, seeded by the group carry-in
  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k +: 4] = chain(g[4*k +: 4], p[4*k +: 4], gc[k])[3:0];
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential 8x8 unsigned shift-and-add multiplier with valid/ready
// handshakes; one shared 16-bit CLA accumulates the partial products.
module shift_add_mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int EARLY_EXIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy,
  output logic [CNT_W-1:0]  cycles
);

  localparam logic EE = (EARLY_EXIT != 0);

  mul_state_t        state;
  mul_state_t        nxt;
  logic [PROD_W-1:0] m;
  logic [OP_W-1:0]   q;
  logic [PROD_W-1:0] p;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] sum;
  logic              load;
  logic              last;

  cla_sixteen u_add (
    .a    (p),
    .b    (m),
    .cin  (1'b0),
    .sum  (sum),
    .cout ()
  );

  assign load = (state == IDLE) && in_valid;
  assign last = (cnt == CNT_W'(7)) || (EE && (q[OP_W-1:1] == '0));

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next state and handshake outputs
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          nxt = (EE && (b == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // operand load and one shift-add step per RUN cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m   <= '0;
      q   <= '0;
      p   <= '0;
      cnt <= '0;
    end else if (load) begin
      m   <= {{(PROD_W-OP_W){1'b0}}, a};
      q   <= b;
      p   <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      if (q[0]) p <= sum;
      m   <= m << 1;
      q   <= q >> 1;
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign product = p;
  assign cycles  = cnt;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Scoreboard bench for shift_add_mul_ctrl, one instance per EARLY_EXIT
// setting; index 1 is the early-exit unit, index 0 the fixed 8-cycle one.
module tb_shift_add_mul_ctrl;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv[2];
  logic [7:0]  ia[2];
  logic [7:0]  ib[2];
  logic        ordy[2];
  logic        ir[2];
  logic        ov[2];
  logic        bz[2];
  logic [15:0] pr[2];
  logic [3:0]  cy[2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   rmode[2];
  bit   pend[2];
  bit   seen[2];
  bit   exp_idle[2];
  int   acc_t[2];
  int   ncnt = 0;
  bit   in_rst = 1'b1;

  always #5 clk = ~clk;

  shift_add_mul_ctrl #(.EARLY_EXIT(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(ia[0]), .b(ib[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .product(pr[0]), .busy(bz[0]), .cycles(cy[0])
  );

  shift_add_mul_ctrl #(.EARLY_EXIT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(ia[1]), .b(ib[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .product(pr[1]), .busy(bz[1]), .cycles(cy[1])
  );

  task automatic chk(string nm, int s, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t",
               nm, s, act, exp, $time);
    end
  endtask

  function automatic int ncyc(logic [7:0] b, int ee);
    if (ee == 0) return 8;
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) return i + 1;
    end
    return 0;
  endfunction

  task automatic push(int s, logic [7:0] a, logic [7:0] b,
                      logic [15:0] p);
    exp_t e;
    e.a = a;
    e.b = b;
    e.prod = p;
    e.cyc = ncyc(b, s);
    if (s == 1) q1.push_back(e);
    else        q0.push_back(e);
  endtask

  task automatic send(int s, logic [7:0] a, logic [7:0] b,
                      logic [15:0] p);
    int k;
    push(s, a, b, p);
    iv[s] = 1'b1;
    ia[s] = a;
    ib[s] = b;
    k = 0;
    @(negedge clk);
    while (!ir[s] && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("accept_timeout", s, 0, 1);
    @(posedge clk);
    #1 iv[s] = 1'b0;
  endtask

  task automatic chk_reset(int s);
    chk("rst_in_ready", s, ir[s], 1);
    chk("rst_out_valid", s, ov[s], 0);
    chk("rst_busy", s, bz[s], 0);
    chk("rst_product", s, pr[s], 0);
    chk("rst_cycles", s, cy[s], 0);
  endtask

  task automatic mon(int s);
    exp_t f;
    if (in_rst) return;
    if (exp_idle[s]) begin
      chk("idle_after_hs", s, {ir[s], ov[s]}, 2'b10);
      exp_idle[s] = 1'b0;
    end
    chk("busy", s, bz[s], pend[s]);
    if (iv[s] && ir[s]) begin
      acc_t[s] = ncnt;
      pend[s]  = 1'b1;
      seen[s]  = 1'b0;
    end
    if (ov[s]) begin
      if (!pend[s]) begin
        chk("spurious_valid", s, 0, 1);
      end else begin
        f = (s == 1) ? q1[0] : q0[0];
        chk("product", s, pr[s], f.prod);
        chk("cycles", s, cy[s], f.cyc);
        if (!seen[s]) begin
          chk("latency", s, ncnt - acc_t[s] - 1, f.cyc);
          seen[s] = 1'b1;
        end
        if (ordy[s]) begin
          if (s == 1) void'(q1.pop_front());
          else        void'(q0.pop_front());
          pend[s]     = 1'b0;
          exp_idle[s] = 1'b1;
        end
      end
    end
  endtask

  // monitor: sample mid-cycle, compare against scoreboard front
  always @(negedge clk) begin
    ncnt++;
    for (int s = 0; s < 2; s++) mon(s);
  end

  // consumer back-pressure: 0 always ready, 1 random, 2 held low
  always @(posedge clk) begin
    #1;
    for (int s = 0; s < 2; s++) begin
      if (rmode[s] == 0)      ordy[s] = 1'b1;
      else if (rmode[s] == 1) ordy[s] = ($urandom_range(0, 2) != 0);
      else                    ordy[s] = 1'b0;
    end
  end

  initial begin
    int k;
    logic [7:0] ra;
    logic [7:0] rb;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0;
      ia[s] = '0;
      ib[s] = '0;
      ordy[s] = 1'b1;
      rmode[s] = 0;
      pend[s] = 1'b0;
      seen[s] = 1'b0;
      exp_idle[s] = 1'b0;
      acc_t[s] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    @(posedge clk);
    #1 in_rst = 1'b0;

    send(1, 8'hFF, 8'hFF, 16'hFE01);
    send(1, 8'h0D, 8'h03, 16'h0027);
    send(1, 8'h5A, 8'h00, 16'h0000);
    send(1, 8'hFF, 8'h01, 16'h00FF);
    send(1, 8'h80, 8'h40, 16'h2000);
    send(0, 8'h0D, 8'h03, 16'h0027);
    send(0, 8'h5A, 8'h00, 16'h0000);
    send(0, 8'h01, 8'h80, 16'h0080);

    // stall the consumer while new operands wait at the input
    k = 0;
    while ((q1.size() != 0) && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1 rmode[1] = 2;
    send(1, 8'h10, 8'h10, 16'h0100);
    iv[1] = 1'b1;
    ia[1] = 8'h01;
    ib[1] = 8'h01;
    push(1, 8'h01, 8'h01, 16'h0001);
    k = 0;
    while (!ov[1] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("valid_timeout", 1, 0, 1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 1, ir[1], 0);
      chk("stall_product", 1, pr[1], 16'h0100);
    end
    rmode[1] = 0;
    k = 0;
    @(negedge clk);
    while (!ir[1] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("reaccept_timeout", 1, 0, 1);
    @(posedge clk);
    #1 iv[1] = 1'b0;
    k = 0;
    while ((q1.size() != 0) && k < 100) begin
      @(posedge clk);
      k++;
    end

    // abort in the 4th RUN cycle
    #1;
    send(1, 8'h12, 8'h80, 16'h0900);
    repeat (3) @(posedge clk);
    #1 begin
      in_rst = 1'b1;
      rst_n = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk_reset(1);
    q1.delete();
    pend[1] = 1'b0;
    seen[1] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 in_rst = 1'b0;
    send(1, 8'h03, 8'h05, 16'h000F);

    // random back-pressure on both units
    rmode[0] = 1;
    rmode[1] = 1;
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(1, ra, rb, 16'(ra) * 16'(rb));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(0, ra, rb, 16'(ra) * 16'(rb));
    end

    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (k >= 300) chk("drain_timeout", 0, 0, 1);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
